// File: rtl/instr_stall_fifo.sv
// Fetch-to-decode instruction buffer: captures fetched instructions while decode
// stalls and replays them in order ahead of live fetch traffic; bypasses when empty.
module instr_stall_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_instr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic             use_q,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             empty, is_full, push, pop, wr_en;

    always_comb begin
        empty      = (count_q == '0);
        is_full    = (count_q == CW'(DEPTH));
        // Once anything is buffered, live fetch must queue behind it to keep order.
        push       = in_valid & (stall | ~empty) & ~flush;
        pop        = ~stall & ~empty & ~flush;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (push && pop) begin
            wr_en  = 1'b1;
            head_d = head_q + PW'(1);
            tail_d = tail_q + PW'(1);
        end else if (push) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                tail_d  = tail_q + PW'(1);
                count_d = count_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (pop) begin
            head_d  = head_q + PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; only the bookkeeping state does.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= in_instr;
        end
    end

    always_comb begin
        out_valid = rst ? 1'b0 : (empty ? in_valid : 1'b1);
        out_instr = empty ? in_instr : mem_q[head_q];
        use_q     = ~empty;
        count     = count_q;
        full      = is_full;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_instr_stall_fifo.sv
// Self-checking bench for instr_stall_fifo: directed vector table, hand sequences
// for full push/pop, flush and async reset, then random traffic against a queue model.
module tb_instr_stall_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             stall = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_instr = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_instr;
    logic             use_q;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mq [$];
    logic             m_ovf = 1'b0;

    instr_stall_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr),
        .out_valid(out_valid), .out_instr(out_instr), .use_q(use_q),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             st;
        logic             v;
        logic [WIDTH-1:0] ins;
        logic             fl;
        logic             e_valid;
        logic [WIDTH-1:0] e_instr;
        logic             e_use;
        int               e_cnt;
        logic             e_full;
        logic             e_ovf;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(logic st, logic v, logic [WIDTH-1:0] ins, logic fl,
                                logic ev, logic [WIDTH-1:0] ei, logic eu, int ec,
                                logic ef, logic eo);
        vec_t r;
        r.st = st; r.v = v; r.ins = ins; r.fl = fl;
        r.e_valid = ev; r.e_instr = ei; r.e_use = eu; r.e_cnt = ec;
        r.e_full = ef; r.e_ovf = eo;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic st, logic v, logic [WIDTH-1:0] ins, logic fl);
        stall = st; in_valid = v; in_instr = ins; flush = fl;
        #2;
    endtask

    // Reference behaviour: a plain queue with a sticky overflow bit.
    task automatic tick();
        bit had;
        @(posedge clk);
        had = (mq.size() != 0);
        if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (!stall && had) void'(mq.pop_front());
            if (in_valid && (stall || had)) begin
                if (mq.size() < DEPTH) mq.push_back(in_instr);
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic chk_model(string tag);
        bit e = (mq.size() == 0);
        chk({tag, ".out_valid"}, int'(out_valid), e ? int'(in_valid) : 1);
        chk({tag, ".out_instr"}, int'(out_instr), e ? int'(in_instr) : int'(mq[0]));
        chk({tag, ".use_q"}, int'(use_q), e ? 0 : 1);
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".full"}, int'(full), (mq.size() == DEPTH) ? 1 : 0);
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    endtask

    task automatic step_model(string tag, logic st, logic v, logic [WIDTH-1:0] ins, logic fl);
        drive(st, v, ins, fl);
        chk_model(tag);
        tick();
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".use_q"}, int'(use_q), 0);
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".full"}, int'(full), 0);
        chk({tag, ".overflow"}, int'(overflow), 0);
    endtask

    initial begin
        // bypass
        vt.push_back(mk(0,1,16'h1111,0, 1,16'h1111,0,0,0,0));
        vt.push_back(mk(0,1,16'h2222,0, 1,16'h2222,0,0,0,0));
        // stall capture and replay
        vt.push_back(mk(1,1,16'hA001,0, 1,16'hA001,0,0,0,0));
        vt.push_back(mk(1,1,16'hA002,0, 1,16'hA001,1,1,0,0));
        vt.push_back(mk(0,1,16'hA003,0, 1,16'hA001,1,2,0,0));
        vt.push_back(mk(0,0,16'h0000,0, 1,16'hA002,1,2,0,0));
        vt.push_back(mk(0,0,16'h0000,0, 1,16'hA003,1,1,0,0));
        vt.push_back(mk(0,0,16'h0000,0, 0,16'h0000,0,0,0,0));
        // fill, overflow, drain
        vt.push_back(mk(1,1,16'hB000,0, 1,16'hB000,0,0,0,0));
        vt.push_back(mk(1,1,16'hB001,0, 1,16'hB000,1,1,0,0));
        vt.push_back(mk(1,1,16'hB002,0, 1,16'hB000,1,2,0,0));
        vt.push_back(mk(1,1,16'hB003,0, 1,16'hB000,1,3,0,0));
        vt.push_back(mk(1,1,16'hB004,0, 1,16'hB000,1,4,1,0));
        vt.push_back(mk(0,0,16'h0000,0, 1,16'hB000,1,4,1,1));
        vt.push_back(mk(0,0,16'h0000,0, 1,16'hB001,1,3,0,1));
        vt.push_back(mk(0,0,16'h0000,0, 1,16'hB002,1,2,0,1));
        vt.push_back(mk(0,0,16'h0000,0, 1,16'hB003,1,1,0,1));
        vt.push_back(mk(0,0,16'h0000,0, 0,16'h0000,0,0,0,1));
        // flush with count 3 and overflow set
        vt.push_back(mk(1,1,16'hD000,0, 1,16'hD000,0,0,0,1));
        vt.push_back(mk(1,1,16'hD001,0, 1,16'hD000,1,1,0,1));
        vt.push_back(mk(1,1,16'hD002,0, 1,16'hD000,1,2,0,1));
        vt.push_back(mk(1,1,16'hD003,1, 1,16'hD000,1,3,0,1));
        vt.push_back(mk(0,1,16'hE000,0, 1,16'hE000,0,0,0,0));

        in_valid = 1'b1; in_instr = 16'h5555;
        #12;
        chk_reset_state("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            string t = $sformatf("vec%0d", i);
            drive(vt[i].st, vt[i].v, vt[i].ins, vt[i].fl);
            chk({t, ".out_valid"}, int'(out_valid), int'(vt[i].e_valid));
            chk({t, ".out_instr"}, int'(out_instr), int'(vt[i].e_instr));
            chk({t, ".use_q"}, int'(use_q), int'(vt[i].e_use));
            chk({t, ".count"}, int'(count), vt[i].e_cnt);
            chk({t, ".full"}, int'(full), int'(vt[i].e_full));
            chk({t, ".overflow"}, int'(overflow), int'(vt[i].e_ovf));
            tick();
        end

        // simultaneous push/pop at full: C0DE reaches the head after four pops
        for (int i = 0; i < 4; i++) step_model("fillc", 1, 1, 16'hC000 + 16'(i), 0);
        drive(0, 1, 16'hC0DE, 0);
        chk("pp_full.count_before", int'(count), 4);
        chk("pp_full.head", int'(out_instr), 16'hC000);
        tick();
        chk("pp_full.count_after", int'(count), 4);
        chk("pp_full.full_after", int'(full), 1);
        for (int i = 0; i < 4; i++) step_model("drainc", 0, 0, 16'h0000, 0);
        step_model("drainc_done", 0, 0, 16'h0000, 0);

        // async reset mid-drain with head=3, tail=1
        step_model("wrapf", 0, 0, 16'h0, 1);
        for (int i = 0; i < 3; i++) step_model("wrap_push", 1, 1, 16'h7000 + 16'(i), 0);
        for (int i = 0; i < 3; i++) step_model("wrap_pop", 0, 0, 16'h0, 0);
        step_model("wrap_a", 1, 1, 16'h7A00, 0);
        step_model("wrap_b", 1, 1, 16'h7B00, 0);
        drive(0, 1, 16'h7C00, 0);
        chk("wrap.count", int'(count), 2);
        chk("wrap.head_instr", int'(out_instr), 16'h7A00);
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        #1 rst = 1'b0;
        mq.delete(); m_ovf = 1'b0;
        #1;
        chk_model("post_rst");
        tick();
        step_model("post_rst_byp", 0, 1, 16'h9999, 0);

        // random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step_model("rand",
                       logic'($urandom_range(0, 99) < 55),
                       logic'($urandom_range(0, 99) < 70),
                       WIDTH'($urandom),
                       logic'($urandom_range(0, 99) < 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
